s1494_state_reg: RTL
====================

Name: s1494_state_reg

Overview:
- Sequential state stage for the s1494 controller.
- Captures the six next-state bits from the combinational partial-output cones (n80 and its siblings) and holds them as the present-state bits v7..v12.
- Feeds those bits back to the cone inputs.
- Provides a scan path and a capture counter so CREsT test benches can load and unload state.

Parameters:
- CNT_W, 8, width of the saturating capture counter.
- SCAN_LEN, 6, number of shifts per full scan load/unload. Fixed to the state width; other values are unsupported.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  synchronous active-low reset; sampled on the rising edge of CK.
- ns_in  in  6  next-state bits from the cones; bit0=v7 … bit5=v12.
- ns_valid  in  1  ns_in is valid this cycle.
- ns_ready  out  1  block accepts ns_in this cycle.
- scan_en  in  1  shift mode request.
- scan_in  in  1  serial scan data, enters bit5.
- scan_out  out  1  serial scan data, equals state_out[0].
- scan_done  out  1  one-cycle pulse after SCAN_LEN consecutive shifts.
- state_out  out  6  present state v7..v12 to the cones.
- state_valid  out  1  state_out holds a captured or fully scanned value.
- cap_cnt  out  CNT_W  number of accepted captures, saturating.
- sig  out  6  MISR signature (see Optional Feature).

Behaviour:
- Reset (CLR=0 at CK rise) overrides everything, including mid-scan. Values: state_out=0, state_valid=0, cap_cnt=0, scan_done=0, shift count=0, sig=0, FSM=IDLE.
- FSM states:
  - IDLE: state not valid.
  - VALID: state captured.
  - SHIFT: scan active.
- ns_ready = ~scan_en, combinational.
- Capture occurs when ns_valid & ns_ready at a CK rise:
  - next cycle: state_out=ns_in, state_valid=1, FSM=VALID.
  - cap_cnt increments; holds at 2^CNT_W-1 once reached.
  - Latency is 1 cycle.
- Hold: no capture and scan_en=0 → all registers hold.
- scan_en=1 at a CK rise (from any state):
  - FSM=SHIFT, state_valid=0.
  - state_out <= {scan_in, state_out[5:1]}.
  - shift count increments.
  - scan_out is state_out[0], combinational from the register, so it is valid before the edge.
- Simultaneous scan_en and ns_valid: scan wins, because ns_ready=0 and no capture occurs; cap_cnt is unchanged.
- scan_done:
  - Registered; high for exactly the cycle following the shift that brings shift count to SCAN_LEN.
  - Shift count then resets to 0.
  - Continued shifting starts a new count.
- scan_en falling:
  - Shift count clears.
  - If the last completed group reached SCAN_LEN with no partial shifts since, FSM=VALID and state_valid=1. Otherwise FSM=IDLE and state_valid=0.
- The counter does not count shifts. The MISR does not update on shifts.

Optional Feature:
- Macro: S1494_MISR_EN.
- Defined: 6-bit MISR with polynomial x^6+x+1, updating only on capture. With f=sig[5]:
  - sig'[0]=f^ns_in[0]
  - sig'[1]=sig[0]^f^ns_in[1]
  - sig'[i]=sig[i-1]^ns_in[i] for i=2..5
  - Reset value is 0.
- Not defined: sig tied to 6'b000000 and no MISR registers exist.

Test Plan:
1. Reset: CLR=0 for 2 cycles with random inputs → state_out=0, state_valid=0, cap_cnt=0, sig=0, scan_done=0. CLR=0 asserted during an active scan also returns all of these to 0.
2. Capture: ns_in=6'b101100, ns_valid=1 for one cycle → next cycle state_out=101100, state_valid=1, cap_cnt=1. With S1494_MISR_EN, sig=101100.
3. Scan unload/load: from state 101100, scan_en=1 for 6 cycles with scan_in=1 →
   - scan_out sampled before each edge = 0,0,1,1,0,1.
   - state_out=111111.
   - scan_done=1 in cycle 7 only.
   - after scan_en drops, state_valid=1.
4. Priority: scan_en=1 and ns_valid=1 with ns_in=010101 together → ns_ready=0, state shifts, cap_cnt unchanged, sig unchanged.
5. Partial scan: 3 shifts then scan_en=0 → no scan_done pulse, state_valid=0, FSM=IDLE. A following capture restores state_valid=1.
6. Saturation (CNT_W=2): 5 consecutive captures → cap_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/s1494_state_reg.sv
// s1494_state_reg
// ---------------
// Present-state register stage for the s1494 controller. The six next-state
// bits produced by the combinational cones are captured here and fed back
// to the cones as the present-state bits v7..v12. A serial scan path lets a
// bench unload and reload the state. A saturating counter records how many
// captures were accepted.
//
// Optional build macro: S1494_MISR_EN
//   defined   : a 6-bit MISR (x^6+x+1) compresses every captured ns_in into sig
//   undefined : sig is tied to zero and no MISR flops exist
//
// Ports
//   CK          in   clock, all state changes on the rising edge
//   CLR         in   synchronous active-low reset
//   ns_in       in   [5:0] next-state bits, bit0=v7 .. bit5=v12
//   ns_valid    in   ns_in valid this cycle
//   ns_ready    out  capture possible this cycle (low while scanning)
//   scan_en     in   shift mode request
//   scan_in     in   serial scan data, enters bit5
//   scan_out    out  serial scan data, always state_out[0]
//   scan_done   out  one-cycle pulse after a full group of SCAN_LEN shifts
//   state_out   out  [5:0] present state v7..v12
//   state_valid out  state_out holds a captured or fully scanned value
//   cap_cnt     out  [CNT_W-1:0] accepted captures, saturating
//   sig         out  [5:0] MISR signature (zero when MISR not built)

module s1494_state_reg #(
    parameter int CNT_W    = 8,
    parameter int SCAN_LEN = 6
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic [5:0]       ns_in,
    input  logic             ns_valid,
    output logic             ns_ready,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    output logic             scan_done,
    output logic [5:0]       state_out,
    output logic             state_valid,
    output logic [CNT_W-1:0] cap_cnt,
    output logic [5:0]       sig
);

    // Shift counter only has to reach SCAN_LEN-1 before wrapping to zero.
    localparam int SW = $clog2(SCAN_LEN + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(SCAN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        SHIFT
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [5:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [SW-1:0]    sc_q, sc_d;
    logic             capture;

    // Scanning blocks capture outright, so a simultaneous ns_valid is simply
    // refused rather than arbitrated.
    assign ns_ready = ~scan_en;
    assign capture  = ns_valid & ns_ready;

    // Serial output taken straight from the register so it is stable for
    // the whole cycle before the shifting edge.
    assign scan_out    = state_q[0];
    assign state_out   = state_q;
    assign state_valid = valid_q;
    assign cap_cnt     = cnt_q;
    assign scan_done   = done_q;

    // Next-state logic. Shift mode has top priority below reset. When shift
    // mode ends, the count is zero only if the last shift completed a full
    // group (SCAN_LEN >= 2 means entering SHIFT always leaves a nonzero
    // count until a group closes), so that alone decides whether the
    // scanned-in value is trustworthy. A capture arriving on the same edge
    // that scan_en drops takes precedence and makes the state valid anyway.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sc_d    = sc_q;

        if (scan_en) begin
            fsm_d   = SHIFT;
            valid_d = 1'b0;
            state_d = {scan_in, state_q[5:1]};
            if (sc_q == SC_LAST) begin
                sc_d   = '0;
                done_d = 1'b1;
            end else begin
                sc_d = sc_q + 1'b1;
            end
        end else begin
            sc_d = '0;
            if (capture) begin
                fsm_d   = VALID;
                state_d = ns_in;
                valid_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (fsm_q == SHIFT) begin
                if (sc_q == '0) begin
                    fsm_d   = VALID;
                    valid_d = 1'b1;
                end else begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                end
            end
        end
    end

    // State register; reset wins over everything, including a scan in
    // progress.
    always_ff @(posedge CK) begin
        if (!CLR) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sc_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sc_q    <= sc_d;
        end
    end

`ifdef S1494_MISR_EN
    logic [5:0] sig_q, sig_d;
    logic       fb;

    // MISR for x^6+x+1: the top bit feeds back into bits 0 and 1. It only
    // advances on an accepted capture, never on shifts.
    always_comb begin
        fb    = sig_q[5];
        sig_d = sig_q;
        if (capture) begin
            sig_d[0] = fb ^ ns_in[0];
            sig_d[1] = sig_q[0] ^ fb ^ ns_in[1];
            for (int i = 2; i < 6; i++) begin
                sig_d[i] = sig_q[i-1] ^ ns_in[i];
            end
        end
    end

    // Signature register, cleared with the rest of the stage.
    always_ff @(posedge CK) begin
        if (!CLR) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 6'b000000;
`endif

endmodule
